// File: rtl/sram_2147_arb_ctl.sv
// Two-port round-robin arbiter and access sequencer for a bank of 4K x 1 SRAM chips.
// Optional parity chip enabled by defining SRAM_2147_ARB_CTL_PARITY_EN.
module sram_2147_arb_ctl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ACCESS_CYCLES = 2,
`ifdef SRAM_2147_ARB_CTL_PARITY_EN
  localparam int unsigned MemWidth     = DATA_WIDTH + 1
`else
  localparam int unsigned MemWidth     = DATA_WIDTH
`endif
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [11:0]           a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_ack_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  output logic                  a_perr_o,
  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [11:0]           b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  b_ack_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic                  b_perr_o,
  output logic [11:0]           sram_addr_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_we_n_o,
  output logic [MemWidth-1:0]   sram_di_o,
  input  logic [MemWidth-1:0]   sram_do_i
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRecover} state_e;

  state_e                state_q;
  logic                  sel_q;   // 1: port B owns the current access
  logic                  last_q;  // 1: port B was granted last
  logic                  we_q;
  logic [3:0]            cnt_q;
  logic                  ce_n_q, we_n_q;
  logic [11:0]           addr_q;
  logic [MemWidth-1:0]   di_q;
  logic                  a_ack_q, b_ack_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

  logic                  grant_b;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic [MemWidth-1:0]   di_d;

  always_comb begin
    grant_b   = b_req_i & (~a_req_i | ~last_q);
    wdata_sel = grant_b ? b_wdata_i : a_wdata_i;
`ifdef SRAM_2147_ARB_CTL_PARITY_EN
    di_d      = {~^wdata_sel, wdata_sel};
`else
    di_d      = wdata_sel;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      cnt_q     <= 4'd0;
      ce_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      addr_q    <= 12'd0;
      di_q      <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (a_req_i | b_req_i) begin
            sel_q   <= grant_b;
            last_q  <= grant_b;
            we_q    <= grant_b ? b_we_i : a_we_i;
            addr_q  <= grant_b ? b_addr_i : a_addr_i;
            di_q    <= di_d;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          ce_n_q  <= 1'b0;
          we_n_q  <= ~we_q;
          cnt_q   <= 4'(ACCESS_CYCLES - 1);
          state_q <= StAccess;
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            state_q <= StRecover;
            if (sel_q) b_ack_q <= 1'b1;
            else       a_ack_q <= 1'b1;
            if (!we_q) begin
              if (sel_q) b_rdata_q <= sram_do_i[DATA_WIDTH-1:0];
              else       a_rdata_q <= sram_do_i[DATA_WIDTH-1:0];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StRecover: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

`ifdef SRAM_2147_ARB_CTL_PARITY_EN
  logic a_perr_q, b_perr_q;

  // Odd parity across all stored bits: an even XOR means a flipped bit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_perr_q <= 1'b0;
      b_perr_q <= 1'b0;
    end else if (state_q == StAccess && cnt_q == 4'd0) begin
      if (sel_q) b_perr_q <= ~we_q & ~(^sram_do_i);
      else       a_perr_q <= ~we_q & ~(^sram_do_i);
    end
  end

  assign a_perr_o = a_perr_q;
  assign b_perr_o = b_perr_q;
`else
  assign a_perr_o = 1'b0;
  assign b_perr_o = 1'b0;
`endif

  assign a_ack_o     = a_ack_q;
  assign b_ack_o     = b_ack_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;
  assign sram_addr_o = addr_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_we_n_o = we_n_q;
  assign sram_di_o   = di_q;

endmodule

// File: tb/tb_sram_2147_arb_ctl.sv
// Scoreboard bench for sram_2147_arb_ctl with a behavioural 4K x MW RAM bank.
// Define SRAM_2147_ARB_CTL_PARITY_EN to exercise the parity chip.
module tb_sram_2147_arb_ctl;
  localparam int unsigned DW = 32;
  localparam int unsigned AC = 2;
`ifdef SRAM_2147_ARB_CTL_PARITY_EN
  localparam int unsigned MW = DW + 1;
`else
  localparam int unsigned MW = DW;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [11:0]   a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic          a_ack, b_ack, a_perr, b_perr;
  logic [11:0]   sram_addr;
  logic          sram_ce_n, sram_we_n;
  logic [MW-1:0] sram_di, sram_do;

  typedef struct {
    logic          we;
    logic [11:0]   addr;
    logic [DW-1:0] data;
    logic          perr;
    int            issue;
    bit            chk_lat;
  } txn_t;

  txn_t          a_q[$], b_q[$];
  int            ord_q[$];
  logic [DW-1:0] ref_mem [4096];
  logic [MW-1:0] mem [4096];
  logic          ram_init, flip;
  int            cyc = 0;
  int            n_cmp = 0, n_err = 0;

  sram_2147_arb_ctl #(.DATA_WIDTH(DW), .ACCESS_CYCLES(AC)) dut (
    .clk_i(clk), .reset_i(reset),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_ack_o(a_ack), .a_rdata_o(a_rdata), .a_perr_o(a_perr),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_ack_o(b_ack), .b_rdata_o(b_rdata), .b_perr_o(b_perr),
    .sram_addr_o(sram_addr), .sram_ce_n_o(sram_ce_n), .sram_we_n_o(sram_we_n),
    .sram_di_o(sram_di), .sram_do_i(sram_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_pat(input int i);
    logic [31:0] t;
    t = 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    return DW'(t);
  endfunction

  // RAM bank: writes on a CE/WE-low edge, DO undriven while deselected.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) begin
`ifdef SRAM_2147_ARB_CTL_PARITY_EN
        mem[i] <= {~^init_pat(i), init_pat(i)};
`else
        mem[i] <= init_pat(i);
`endif
      end
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr] <= sram_di;
    end
`ifdef SRAM_2147_ARB_CTL_PARITY_EN
    else if (flip) begin
      mem[12'h010][DW] <= ~mem[12'h010][DW];
    end
`endif
  end
  assign sram_do = sram_ce_n ? 'x : mem[sram_addr];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor state
  int            wlow;
  bit            we_seen, prev_act;
  logic [11:0]   prev_addr;
  logic [MW-1:0] prev_di;
  logic [DW-1:0] last_rd [2];

  task automatic on_ack(input bit port);
    txn_t          t;
    bit            have;
    logic [DW-1:0] rd;
    logic          pe;
    rd   = port ? b_rdata : a_rdata;
    pe   = port ? b_perr : a_perr;
    have = port ? (b_q.size() != 0) : (a_q.size() != 0);
    check_eq(port ? "b_ack_expected" : "a_ack_expected", 64'(have), 64'd1);
    if (!have) return;
    if (port) t = b_q.pop_front();
    else      t = a_q.pop_front();
    if (ord_q.size() != 0) check_eq("grant_order", 64'(port), 64'(ord_q.pop_front()));
    check_eq("ack_addr", 64'(sram_addr), 64'(t.addr));
    check_eq("we_n_activity", 64'(we_seen), 64'(t.we));
    if (t.we) begin
      check_eq("write_di", 64'(sram_di[DW-1:0]), 64'(t.data));
      check_eq("rdata_kept_on_write", 64'(rd), 64'(last_rd[port]));
    end else begin
      check_eq("read_data", 64'(rd), 64'(t.data));
      last_rd[port] = t.data;
    end
    check_eq("perr", 64'(pe), 64'(t.perr));
    if (t.chk_lat) check_eq("latency", 64'(cyc - t.issue), 64'(AC + 2));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      wlow     = 0;
      we_seen  = 1'b0;
      prev_act = 1'b0;
      last_rd  = '{default: '0};
    end else begin
      if (!sram_we_n) check_eq("we_n_needs_ce_n", 64'(sram_ce_n), 64'd0);
      if (!sram_ce_n || !sram_we_n) begin
        if (prev_act) begin
          check_eq("addr_stable", 64'(sram_addr), 64'(prev_addr));
          check_eq("di_stable", 64'(sram_di), 64'(prev_di));
        end
        prev_act  = 1'b1;
        prev_addr = sram_addr;
        prev_di   = sram_di;
      end else begin
        prev_act = 1'b0;
      end
      if (!sram_we_n) begin
        wlow++;
        we_seen = 1'b1;
      end else if (wlow != 0) begin
        check_eq("we_n_low_len", 64'(wlow), 64'(AC));
        wlow = 0;
      end
      if (a_ack || b_ack) check_eq("ack_exclusive", 64'(a_ack & b_ack), 64'd0);
      if (a_ack) on_ack(1'b0);
      if (b_ack) on_ack(1'b1);
      if (a_ack || b_ack) we_seen = 1'b0;
    end
  end

  // Called at #1 after a clock edge while the controller is idle.
  task automatic xfer(input bit port, input bit we, input logic [11:0] addr,
                      input logic [DW-1:0] data, input bit chk_lat, input logic exp_perr = 1'b0);
    txn_t t;
    bit   got;
    t.we = we; t.addr = addr; t.perr = exp_perr; t.issue = cyc; t.chk_lat = chk_lat;
    if (we) begin
      ref_mem[addr] = data;
      t.data = data;
    end else begin
      t.data = ref_mem[addr];
    end
    if (port) begin
      b_q.push_back(t);
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    end else begin
      a_q.push_back(t);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      got = port ? b_ack : a_ack;
    end
    check_eq("ack_timeout", 64'(got), 64'd1);
    if (port) b_req = 1'b0;
    else      a_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int nb;
    bit seen;
    reset = 1'b1; ram_init = 1'b1; flip = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_pat(i);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ce_n", 64'(sram_ce_n), 64'd1);
    check_eq("rst_we_n", 64'(sram_we_n), 64'd1);
    check_eq("rst_addr", 64'(sram_addr), 64'd0);
    check_eq("rst_di", 64'(sram_di), 64'd0);
    check_eq("rst_acks", 64'({a_ack, b_ack}), 64'd0);
    check_eq("rst_rdata", 64'(a_rdata | b_rdata), 64'd0);
    check_eq("rst_perr", 64'({a_perr, b_perr}), 64'd0);
    ram_init = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    xfer(1'b0, 1'b1, 12'h123, 32'hDEAD_BEEF, 1'b1);
    xfer(1'b0, 1'b0, 12'h123, '0, 1'b1);

    // Both ports held high after reset: grants must alternate starting with A.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      a_q.push_back('{we: 1'b0, addr: 12'h055, data: ref_mem[12'h055], perr: 1'b0,
                      issue: 0, chk_lat: 1'b0});
      b_q.push_back('{we: 1'b0, addr: 12'h0AA, data: ref_mem[12'h0AA], perr: 1'b0,
                      issue: 0, chk_lat: 1'b0});
      ord_q.push_back(0);
      ord_q.push_back(1);
    end
    a_we = 0; a_addr = 12'h055; b_we = 0; b_addr = 12'h0AA;
    a_req = 1'b1; b_req = 1'b1;
    nb = 0;
    for (int i = 0; i < 200 && nb < 2; i++) begin
      @(posedge clk); #1;
      if (b_ack) nb++;
    end
    check_eq("held_b_acks", 64'(nb), 64'd2);
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;

    xfer(1'b1, 1'b1, 12'hFFF, 32'h0000_0001, 1'b1);
    xfer(1'b1, 1'b1, 12'h000, 32'h8000_0000, 1'b1);
    xfer(1'b1, 1'b0, 12'hFFF, '0, 1'b1);
    xfer(1'b1, 1'b0, 12'h000, '0, 1'b1);

    // Abort a write in its first access cycle.
    a_we = 1'b1; a_addr = 12'h300; a_wdata = 32'h5555_AAAA; a_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      seen = !sram_ce_n;
    end
    check_eq("abort_reached_access", 64'(seen), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_ce_n", 64'(sram_ce_n), 64'd1);
    check_eq("abort_we_n", 64'(sram_we_n), 64'd1);
    check_eq("abort_no_ack", 64'(a_ack), 64'd0);
    reset = 1'b0; a_req = 1'b0;
    repeat (AC + 4) @(posedge clk);
    #1;
    xfer(1'b0, 1'b0, 12'h301, '0, 1'b1);

    // Mixed traffic; ports use disjoint halves so each port's queue order is the model order.
    fork
      for (int i = 0; i < 40; i++) begin
        xfer(1'b0, 1'($urandom_range(0, 1)), {8'h00, 4'($urandom_range(0, 15))}, $urandom, 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
      end
      for (int i = 0; i < 40; i++) begin
        xfer(1'b1, 1'($urandom_range(0, 1)), {8'h80, 4'($urandom_range(0, 15))}, $urandom, 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
      end
    join
    @(posedge clk); #1;

`ifdef SRAM_2147_ARB_CTL_PARITY_EN
    xfer(1'b0, 1'b1, 12'h010, 32'h0000_0000, 1'b1);
    xfer(1'b0, 1'b0, 12'h010, '0, 1'b1, 1'b0);
    flip = 1'b1;
    @(posedge clk); #1;
    flip = 1'b0;
    xfer(1'b0, 1'b0, 12'h010, '0, 1'b1, 1'b1);
`endif

    repeat (4) @(posedge clk);
    #1;
    check_eq("a_queue_drained", 64'(a_q.size()), 64'd0);
    check_eq("b_queue_drained", 64'(b_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_2147_arb_ctl.md
Name: sram_2147_arb_ctl

Overview:
- Sequencer and two-port arbiter for a bank of 4K x 1 static RAM chips wired side by side into a DATA_WIDTH-bit word.
- Generates the chip address, CE_N, WE_N and DI timing, and samples DO.
- Shares the bank between port A (processor side) and port B (bus/debug side) with round-robin priority.
- Sits between the requesters and the physical RAM chip instances.

Parameters:
- DATA_WIDTH, 32: data bits per word, one 4K x 1 chip per bit.
- ACCESS_CYCLES, 2: clocks CE_N is held low per access; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request level; held until a_ack.
- a_we  in  1  port A write (1) / read (0); stable while a_req=1.
- a_addr  in  12  port A word address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_ack  out  1  one-cycle completion pulse.
- a_rdata  out  DATA_WIDTH  port A read data.
- a_perr  out  1  port A parity error, valid with a_ack.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_perr: same as port A, for port B.
- sram_addr  out  12  address to all chips.
- sram_ce_n  out  1  chip enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_di  out  MW  data to chips; MW = DATA_WIDTH (+1 with PARITY_EN).
- sram_do  in  MW  data from chips; high-Z/X when sram_ce_n=1 and must be ignored then.

Behaviour:
- All outputs are registered.
- Reset values: sram_ce_n=1, sram_we_n=1, sram_addr=0, sram_di=0, acks=0, rdata=0, perr=0, FSM=IDLE, last_grant=B (port A wins the first tie).
- Reset mid-access aborts the access immediately: ce_n/we_n go to 1 on the reset edge, and no ack is issued.
- FSM states:
  - IDLE: if any req is high, select a port and latch we/addr/wdata into internal registers. Go to SETUP.
  - SETUP (1 clk): sram_addr and sram_di driven from the latched values; ce_n=1, we_n=1.
  - ACCESS (ACCESS_CYCLES clks): ce_n=0; we_n=0 for a write, 1 for a read; address and DI held stable.
  - ACCESS exit: on the edge that leaves ACCESS, a read captures sram_do into the selected port's rdata register.
  - RECOVER (1 clk): ce_n=1, we_n=1, address and DI still held. The selected port's ack=1 for exactly this cycle. Next state is IDLE.
- Latency: request sampled at edge 0 → ack high during cycle ACCESS_CYCLES+2; minimum 4 clocks per access, request to request.
- we_n is never low while ce_n=1. we_n never changes while the address changes. The address changes only in IDLE.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting in IDLE: the port not equal to last_grant wins.
  - last_grant updates on every grant.
  - A port dropping req before its ack is a protocol violation; the access still completes and acks.
- Port behaviour:
  - Requesters must deassert req on the cycle after ack, or present a new request (it is treated as new).
  - rdata holds its value until that port's next read ack. A write ack leaves rdata unchanged.
  - A write followed by a read of the same address returns the written data.
- Address wraps naturally: 12 bits, 0x000..0xFFF; no out-of-range state.

Optional Feature:
- Macro: SRAM_2147_ARB_CTL_PARITY_EN.
- With the macro:
  - MW=DATA_WIDTH+1; sram_di[DATA_WIDTH] = odd parity of wdata (XOR of data bits, inverted).
  - On a read, perr = (XOR of all MW sram_do bits == 0), registered alongside rdata and presented with ack.
  - perr is 0 on write acks.
- Without the macro: MW=DATA_WIDTH, no parity chip, a_perr and b_perr are tied to 0.

Test Plan:
- Write then read, ACCESS_CYCLES=2:
  - Stimulus: A writes 0xDEADBEEF to 0x123, then reads 0x123.
  - Response: each ack arrives 4 clks after the request edge; a_rdata=0xDEADBEEF; we_n low for exactly 2 clks on the write and never low on the read.
- Simultaneous requests after reset:
  - Stimulus: A and B both request, held continuously.
  - Response: grant order A,B,A,B; each ack pulse is 1 clk wide and goes to the correct port; no cycle has both acks high.
- Address wrap and endpoints:
  - Stimulus: B writes 0x00000001 to 0xFFF and 0x80000000 to 0x000, then reads both.
  - Response: reads return the matching values; sram_addr equals exactly 0xFFF or 0x000.
- Reset mid-write:
  - Stimulus: assert reset during the first ACCESS cycle of a write.
  - Response: ce_n=1 and we_n=1 on the next edge; no ack; FSM in IDLE; a subsequent read of an untouched address completes normally.
- Timing checker, ACCESS_CYCLES=1 and ACCESS_CYCLES=5:
  - Stimulus: random mixed traffic on both ports.
  - Response:
    - sram_addr and sram_di are stable whenever ce_n=0 or we_n=0.
    - Latencies are 3 and 7 clks respectively.
    - Reads match a reference model.
- PARITY_EN build:
  - Stimulus: write 0x00000000 to 0x010, then flip the stored parity bit in the RAM model and read back.
  - Response: the first read gives perr=0; after the flip, perr=1 with rdata=0x00000000.
